delaychain_sequencer: RTL



---
 rtl/delaychain_pkg.sv | 22 ++
 rtl/delaychain_sync.sv | 23 ++
 rtl/delaychain_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/delaychain_pkg.sv
// Shared types and default constants for the delay-chain measurement controller.
package delaychain_pkg;

    localparam int DC_N_CHAINS   = 8;
    localparam int DC_CNT_W      = 16;
    localparam int DC_SETTLE_CYC = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        LAUNCH  = 3'd2,
        MEASURE = 3'd3,
        DONE    = 3'd4
    } state_t;

    typedef struct packed {
        logic [DC_CNT_W-1:0] count;
        logic                timeout;
        logic                err;
    } result_t;

endpackage

// File: rtl/delaychain_sync.sv
// Two-flop synchronizer for a vector of independent asynchronous bits.
module delaychain_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/delaychain_sequencer.sv
// Selects one delay chain, settles it, toggles its input and counts cycles until
// the synchronized output follows; the result goes out on a valid/ready port.
module delaychain_sequencer
    import delaychain_pkg::*;
#(
    parameter int N_CHAINS   = DC_N_CHAINS,
    parameter int SEL_W      = 3,
    parameter int CNT_W      = DC_CNT_W,
    parameter int SETTLE_CYC = DC_SETTLE_CYC,
    parameter int TIMEOUT    = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [SEL_W-1:0]    chain_sel,
    input  logic                test_mode,
    output logic                busy,
    output logic [N_CHAINS-1:0] chain_din,
    output logic                chain_test,
    input  logic [N_CHAINS-1:0] chain_dout,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [CNT_W-1:0]    result_count,
    output logic                result_timeout,
    output logic                result_err,
    output logic [2:0]          dbg_state
);

    // Handshake: the result fields are valid while result_valid is high and are
    // held unchanged until the cycle where result_valid and result_ready are both high.

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q;
    logic [CNT_W-1:0]    counter;
    logic                baseline;
    logic [N_CHAINS-1:0] sync_q;
    logic                sel_bit;
    logic [N_CHAINS-1:0] sel_mask;
    logic                sel_ok;
    logic                settle_end;
    logic                seen_change;
    logic                timed_out;

    delaychain_sync #(.W(N_CHAINS)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (chain_dout),
        .q   (sync_q)
    );

    // Decoded view of the latched chain: its synchronized output and a one-hot toggle mask.
    always_comb begin
        sel_bit  = 1'b0;
        sel_mask = '0;
        for (int i = 0; i < N_CHAINS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_bit     = sync_q[i];
                sel_mask[i] = 1'b1;
            end
        end
    end

    assign sel_ok      = int'(chain_sel) < N_CHAINS;
    assign settle_end  = counter == CNT_W'(SETTLE_CYC - 1);
    assign seen_change = sel_bit != baseline;
    assign timed_out   = counter == CNT_W'(TIMEOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = sel_ok ? SETTLE : DONE;
            SETTLE:  if (settle_end) state_d = LAUNCH;
            LAUNCH:  state_d = MEASURE;
            MEASURE: if (seen_change || timed_out) state_d = DONE;
            DONE:    if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy         = state_q != IDLE;
        result_valid = state_q == DONE;
        dbg_state    = state_q;
    end

    // Datapath registers; chain_din only ever toggles, so each chain alternates edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q          <= '0;
            counter        <= '0;
            baseline       <= 1'b0;
            chain_din      <= '0;
            chain_test     <= 1'b0;
            result_count   <= '0;
            result_timeout <= 1'b0;
            result_err     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_q      <= chain_sel;
                        chain_test <= test_mode;
                        counter    <= '0;
                        if (!sel_ok) begin
                            result_count   <= '0;
                            result_timeout <= 1'b0;
                            result_err     <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    counter <= counter + 1'b1;
                    if (settle_end) baseline <= sel_bit;
                end
                LAUNCH: begin
                    chain_din <= chain_din ^ sel_mask;
                    counter   <= '0;
                end
                MEASURE: begin
                    if (seen_change) begin
                        result_count   <= counter;
                        result_timeout <= 1'b0;
                        result_err     <= 1'b0;
                    end else if (timed_out) begin
                        result_count   <= CNT_W'(TIMEOUT);
                        result_timeout <= 1'b1;
                        result_err     <= 1'b0;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
